prim_dom_and_sched: RTL and testbench

- Sequencer and arbiter that time-shares one internal prim_dom_and_2share (Pipeline=0) between NumReq masked requesters.
- Enforces the multiplier's input-stability requirement: operands are latched and held from grant through response.
- Fetches one fresh DW-bit random word per operation, pulses z_valid for exactly one cycle, then returns (q0,q1) tagged with requester ID.
- Sits between masked datapath clients (e.g. S-box/Keccak chi slices) and the shared entropy source.

---
 rtl/prim_dom_and_sched_pkg.sv | 15 +
 rtl/prim_dom_and_2share.sv | 56 +++++
 rtl/prim_dom_and_sched_rr.sv | 34 +++
 rtl/prim_dom_and_sched.sv | 143 ++++++++++++++
 tb/tb_prim_dom_and_sched.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prim_dom_and_sched_pkg.sv
// Shared types and defaults for the DOM-AND scheduler.
// Optional build macro: PRIM_DOM_AND_SCHED_CLEAR_EN (see prim_dom_and_sched.sv).
package prim_dom_and_sched_pkg;

  localparam int unsigned DefaultDW     = 8;
  localparam int unsigned DefaultNumReq = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RND = 2'd1,
    COMPUTE  = 2'd2,
    RESP     = 2'd3
  } sched_st_e;

endpackage

// File: rtl/prim_dom_and_2share.sv
// Two-share domain-oriented masked AND. Cross-domain terms are remasked with z_i
// and registered on z_valid_i; inputs must stay stable while the result is used.
module prim_dom_and_2share #(
  parameter int unsigned DW       = 2,
  parameter bit          Pipeline = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  input  logic          z_valid_i,
  input  logic [DW-1:0] z_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] t0_d, t1_d, t0_q, t1_q;
  logic [DW-1:0] in0, in1;

  assign t0_d = (a0_i & b1_i) ^ z_i;
  assign t1_d = (a1_i & b0_i) ^ z_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t0_q <= '0;
      t1_q <= '0;
    end else if (z_valid_i) begin
      t0_q <= t0_d;
      t1_q <= t1_d;
    end
  end

  if (Pipeline) begin : gen_inner_reg
    logic [DW-1:0] i0_q, i1_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        i0_q <= '0;
        i1_q <= '0;
      end else if (z_valid_i) begin
        i0_q <= a0_i & b0_i;
        i1_q <= a1_i & b1_i;
      end
    end
    assign in0 = i0_q;
    assign in1 = i1_q;
  end else begin : gen_inner_comb
    assign in0 = a0_i & b0_i;
    assign in1 = a1_i & b1_i;
  end

  assign q0_o = in0 ^ t0_q;
  assign q1_o = in1 ^ t1_q;

endmodule

// File: rtl/prim_dom_and_sched_rr.sv
// Combinational round-robin pick: first set request at or after ptr_i, with wrap-around.
// Pointer state is owned by the parent.
module prim_dom_and_sched_rr
  import prim_dom_and_sched_pkg::*;
#(
  parameter  int unsigned NumReq = DefaultNumReq,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  logic [IdW:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_i} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NumReq)) cand = cand - (IdW+1)'(NumReq);
      if (!any_o && req_i[cand[IdW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IdW-1:0];
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/prim_dom_and_sched.sv
// Round-robin sequencer time-sharing one prim_dom_and_2share between NumReq requesters.
// Define PRIM_DOM_AND_SCHED_CLEAR_EN to wipe operand/random regs on the response handshake.
module prim_dom_and_sched
  import prim_dom_and_sched_pkg::*;
#(
  parameter  int unsigned DW     = DefaultDW,
  parameter  int unsigned NumReq = DefaultNumReq,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  logic [NumReq*DW-1:0] req_a0_i,
  input  logic [NumReq*DW-1:0] req_a1_i,
  input  logic [NumReq*DW-1:0] req_b0_i,
  input  logic [NumReq*DW-1:0] req_b1_i,
  output logic                 rnd_req_o,
  input  logic                 rnd_ack_i,
  input  logic [DW-1:0]        rnd_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdW-1:0]       rsp_id_o,
  output logic [DW-1:0]        rsp_q0_o,
  output logic [DW-1:0]        rsp_q1_o,
  output logic                 busy_o
);

  sched_st_e       state_q;
  logic [IdW-1:0]  ptr_q, ptr_d, id_q;
  logic [DW-1:0]   a0_q, a1_q, b0_q, b1_q, z_q;
  logic [NumReq-1:0] gnt;
  logic [IdW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            z_valid;
  logic [DW-1:0]   mul_q0, mul_q1;

  prim_dom_and_sched_rr #(
    .NumReq (NumReq)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign ptr_d = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      z_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q <= WAIT_RND;
            ptr_q   <= ptr_d;
            id_q    <= gnt_idx;
            a0_q    <= req_a0_i[gnt_idx*DW +: DW];
            a1_q    <= req_a1_i[gnt_idx*DW +: DW];
            b0_q    <= req_b0_i[gnt_idx*DW +: DW];
            b1_q    <= req_b1_i[gnt_idx*DW +: DW];
          end
        end
        WAIT_RND: begin
          if (rnd_ack_i) begin
            z_q     <= rnd_data_i;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: state_q <= RESP;
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
`ifdef PRIM_DOM_AND_SCHED_CLEAR_EN
            a0_q <= '0;
            a1_q <= '0;
            b0_q <= '0;
            b1_q <= '0;
            z_q  <= '0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is combinational in IDLE; qualify with reset so ready is 0 while held in reset.
  assign req_ready_o = (state_q == IDLE && rst_ni) ? gnt : '0;
  assign rnd_req_o   = (state_q == WAIT_RND);
  assign z_valid     = (state_q == COMPUTE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);

  prim_dom_and_2share #(
    .DW       (DW),
    .Pipeline (1'b0)
  ) u_and (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a0_i      (a0_q),
    .a1_i      (a1_q),
    .b0_i      (b0_q),
    .b1_i      (b1_q),
    .z_valid_i (z_valid),
    .z_i       (z_q),
    .q0_o      (mul_q0),
    .q1_o      (mul_q1)
  );

  assign rsp_id_o = rsp_valid_o ? id_q   : '0;
  assign rsp_q0_o = rsp_valid_o ? mul_q0 : '0;
  assign rsp_q1_o = rsp_valid_o ? mul_q1 : '0;

`ifndef SYNTHESIS
  logic zv_seen_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               zv_seen_q <= 1'b0;
    else if (|req_ready_o)     zv_seen_q <= 1'b0;
    else if (z_valid)          zv_seen_q <= 1'b1;
  end

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_single_zvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    z_valid |-> !zv_seen_q);
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_id_o) &&
                                       $stable(rsp_q0_o) && $stable(rsp_q1_o)));
  a_unmasked_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_o |-> ((rsp_q0_o ^ rsp_q1_o) == ((a0_q ^ a1_q) & (b0_q ^ b1_q))));
`endif

endmodule

// File: tb/tb_prim_dom_and_sched.sv
// Scoreboard bench for prim_dom_and_sched: grants push expectations, response handshakes pop them.
module tb_prim_dom_and_sched;

  localparam int DW = 8;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] a0, a1, b0, b1;
  logic            rnd_req, rnd_ack;
  logic [DW-1:0]   rnd_data;
  logic            rsp_valid, rsp_ready;
  logic            rsp_id;
  logic [DW-1:0]   rsp_q0, rsp_q1;
  logic            busy;

  prim_dom_and_sched #(.DW(DW), .NumReq(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a0_i    (a0),
    .req_a1_i    (a1),
    .req_b0_i    (b0),
    .req_b1_i    (b1),
    .rnd_req_o   (rnd_req),
    .rnd_ack_i   (rnd_ack),
    .rnd_data_i  (rnd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_q0_o    (rsp_q0),
    .rsp_q1_o    (rsp_q1),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  a0, a1, b0, b1, z;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$], g_cyc_log[$], hs_cyc_log[$], rspf_log[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, ack_wait = 0, resp_wait = 0, wait_cnt = 0, resp_cnt = 0;
  int   stall_cnt = 0, zv_cnt = 0;
  int   last_g_cyc = 0, last_ack_cyc = 0, first_rsp_cyc = 0;
  int   rereq [NR];
  logic [NR-1:0] last_ready;
  logic [7:0]    rnd_next;
  logic          prev_rsp_valid = 1'b0, prev_rsp_ready = 1'b0;
  logic [16:0]   prev_rsp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] va0, va1, vb0, vb1);
    a0[i*DW +: DW] = va0;
    a1[i*DW +: DW] = va1;
    b0[i*DW +: DW] = vb0;
    b1[i*DW +: DW] = vb1;
    req_valid[i]   = 1'b1;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // One cycle: drive responders at negedge, sample at negedge+1, advance to the next negedge.
  task automatic tick();
    int   g;
    logic granted;
    exp_t e;
    logic [7:0] pa, pb;
    granted   = 1'b0;
    g         = 0;
    rnd_ack   = 1'b0;
    rsp_ready = 1'b0;
    if (rst_n && rnd_req && wait_cnt >= ack_wait) begin
      rnd_ack  = 1'b1;
      rnd_data = rnd_next;
      rnd_next = 8'($urandom);
    end
    if (rst_n && rsp_valid && resp_cnt >= resp_wait) rsp_ready = 1'b1;
    #1;
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", {10'd0, req_ready, rnd_req, rsp_valid, rsp_id, rsp_q0, rsp_q1, busy}, '0);
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        g = req_ready[1] ? 1 : 0;
        check("grant_valid", req_valid[g], 1'b1);
        check("grant_not_busy", busy, 1'b0);
        e.id = g;
        e.a0 = a0[g*DW +: DW]; e.a1 = a1[g*DW +: DW];
        e.b0 = b0[g*DW +: DW]; e.b1 = b1[g*DW +: DW];
        e.z  = '0;
        sb.push_back(e);
        grant_log.push_back(g);
        g_cyc_log.push_back(cyc);
        last_g_cyc = cyc;
        last_ready = req_ready;
        zv_cnt     = 0;
        granted    = 1'b1;
      end
      if (busy) check("no_grant_busy", req_ready, '0);
      if (dut.z_valid) zv_cnt++;
      if (rnd_req) begin
        check("busy_in_wait", busy, 1'b1);
        check("no_z_in_wait", dut.z_valid, 1'b0);
        if (rnd_ack) begin
          last_ack_cyc = cyc;
          wait_cnt     = 0;
          if (sb.size() > 0) sb[sb.size()-1].z = rnd_data;
        end else begin
          wait_cnt++;
          stall_cnt++;
        end
      end
      if (rsp_valid) begin
        if (!prev_rsp_valid) begin
          first_rsp_cyc = cyc;
          rspf_log.push_back(cyc);
          check("rsp_after_ack", cyc - last_ack_cyc, 2);
        end else if (!prev_rsp_ready) begin
          check("rsp_stable", {rsp_id, rsp_q0, rsp_q1}, prev_rsp);
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e  = sb.pop_front();
            pa = e.a0 ^ e.a1;
            pb = e.b0 ^ e.b1;
            check("rsp_id", rsp_id, e.id);
            check("rsp_unmasked", rsp_q0 ^ rsp_q1, pa & pb);
            check("rsp_q0", rsp_q0, (e.a0 & e.b0) ^ (e.a0 & e.b1) ^ e.z);
            check("zvalid_once", zv_cnt, 1);
          end
          hs_cyc_log.push_back(cyc);
          resp_cnt = 0;
        end else begin
          resp_cnt++;
        end
      end else begin
        if (prev_rsp_valid && !prev_rsp_ready) check("rsp_dropped", 0, 1);
        check("rsp_gated", {rsp_id, rsp_q0, rsp_q1}, '0);
      end
    end
    prev_rsp_valid = rsp_valid;
    prev_rsp_ready = rsp_ready;
    prev_rsp       = {rsp_id, rsp_q0, rsp_q1};
    @(negedge clk);
    if (granted) begin
      if (rereq[g] > 0) begin
        rereq[g]--;
        set_req_rand(g);
      end else begin
        req_valid[g] = 1'b0;
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((req_valid != '0 || busy || sb.size() != 0) && n < budget);
    if (n >= budget) check("timeout_idle", n, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    check("ptr_reset", dut.ptr_q, 0);
    rst_n = 1'b1;
    sb.delete();
    grant_log.delete(); g_cyc_log.delete(); hs_cyc_log.delete(); rspf_log.delete();
    wait_cnt = 0; resp_cnt = 0; zv_cnt = 0; stall_cnt = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    rnd_ack   = 1'b0;
    rnd_data  = '0;
    rsp_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    rnd_next = 8'($urandom);
    for (int i = 0; i < NR; i++) rereq[i] = 0;
    @(negedge clk);

    // Outputs stay 0 while reset is held even with requests pending
    set_req_rand(0);
    set_req_rand(1);
    tick();
    tick();
    req_valid = '0;
    do_reset();

    // Single op with the reference operands
    rnd_next = 8'h96;
    set_req(0, 8'h3C, 8'h0F, 8'hA5, 8'hFF);
    run_idle(30);
    check("t1_ready_at_grant", last_ready, 2'b01);
    check("t1_ack_lat", last_ack_cyc - last_g_cyc, 1);
    check("t1_rsp_lat", first_rsp_cyc - last_g_cyc, 3);
    check("t1_grant_id", grant_log[0], 0);
`ifdef PRIM_DOM_AND_SCHED_CLEAR_EN
    check("t1_a0_reg", dut.a0_q, 8'h00);
    check("t1_b1_reg", dut.b1_q, 8'h00);
    check("t1_z_reg",  dut.z_q,  8'h00);
`else
    check("t1_a0_reg", dut.a0_q, 8'h3C);
    check("t1_b1_reg", dut.b1_q, 8'hFF);
    check("t1_z_reg",  dut.z_q,  8'h96);
`endif

    // Contention: both valid from reset, requester 0 re-requests once
    do_reset();
    rereq[0] = 1;
    set_req_rand(0);
    set_req_rand(1);
    run_idle(100);
    check("cont_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("cont_g0", grant_log[0], 0);
      check("cont_g1", grant_log[1], 1);
      check("cont_g2", grant_log[2], 0);
    end

    // Entropy stall of 5 cycles
    do_reset();
    ack_wait = 5;
    set_req_rand(1);
    run_idle(60);
    check("stall_cycles", stall_cnt, 5);
    ack_wait = 0;

    // Backpressure: consumer holds off 4 cycles while requester 1 waits
    do_reset();
    resp_wait = 4;
    set_req_rand(0);
    set_req_rand(1);
    run_idle(80);
    resp_wait = 0;
    check("bp_ops", hs_cyc_log.size(), 2);
    if (hs_cyc_log.size() == 2 && rspf_log.size() == 2 && g_cyc_log.size() == 2) begin
      check("bp_hold", hs_cyc_log[0] - rspf_log[0], 4);
      check("bp_bubble", g_cyc_log[1] - hs_cyc_log[0], 1);
      check("bp_order", grant_log[1], 1);
    end

    // Reset during COMPUTE with requester 1 pending
    do_reset();
    set_req_rand(0);
    set_req_rand(1);
    n = 0;
    while (!dut.z_valid && n < 20) begin
      tick();
      n++;
    end
    check("rst_reach_compute", dut.z_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rst_ptr", dut.ptr_q, 0);
    rst_n = 1'b1;
    sb.delete();
    grant_log.delete();
    wait_cnt = 0; resp_cnt = 0; zv_cnt = 0;
    run_idle(40);
    check("rst_regrant_count", grant_log.size(), 1);
    if (grant_log.size() == 1) check("rst_regrant_id", grant_log[0], 1);

    // Random traffic with random entropy and consumer delays
    for (int k = 0; k < 12; k++) begin
      int mask;
      mask      = $urandom_range(1, 3);
      ack_wait  = $urandom_range(0, 3);
      resp_wait = $urandom_range(0, 3);
      for (int i = 0; i < NR; i++)
        if (mask[i]) set_req_rand(i);
      run_idle(100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
